// File: rtl/image_reader.sv
// Streams one IMG_W x IMG_H frame from a 24-bit image RAM (1-cycle read
// latency) into a valid/ready pixel stream. Each pixel carries its (x, y)
// coordinates and start-of-frame / end-of-line flags. The reader can loop
// over frames continuously, and it can be aborted at any time.
module image_reader #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_loop,
  input  logic        i_stop,
  output logic [13:0] o_ram_addr,
  output logic        o_ram_rd,
  input  logic [23:0] i_ram_q,
  output logic [23:0] o_pixel,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [6:0]  o_x,
  output logic [6:0]  o_y,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [13:0] LAST_ADDR = 14'(IMG_W * IMG_H - 1);
  localparam logic [6:0]  X_LAST    = 7'(IMG_W - 1);
  localparam logic [6:0]  Y_LAST    = 7'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [23:0] pixel;
    logic [6:0]  x;
    logic [6:0]  y;
  } entry_t;

  state_t      state;
  logic [13:0] addr;
  logic [6:0]  rd_x, rd_y;   // coordinates of the next read to issue
  logic        inflight;     // a read was issued last cycle; data is on i_ram_q now
  logic [6:0]  fl_x, fl_y;   // coordinates of that in-flight read
  entry_t      fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  entry_t      head;
  logic        push, pop, issue, head_last;

  // Handshake, read-issue decision and output decode from the FIFO head.
  always_comb begin
    // NOTE: every signal gets a default here first, so no path leaves it unassigned and no latch is inferred.
    head      = fifo_mem[rd_ptr];
    o_valid   = (count != 2'd0);
    pop       = o_valid && i_ready;
    push      = inflight;
    head_last = (head.x == X_LAST) && (head.y == Y_LAST);
    // Issue only if the entry can land without overflowing the FIFO, counting
    // the read already in flight and the pop happening this cycle.
    issue     = (state == S_RUN) && !i_stop &&
                ((3'(count) + 3'(inflight) - 3'(pop)) < 3'd2);
    o_ram_rd   = issue;
    o_ram_addr = addr;
    o_busy     = (state != S_IDLE);
    o_pixel    = o_valid ? head.pixel : 24'd0;
    o_x        = o_valid ? head.x : 7'd0;
    o_y        = o_valid ? head.y : 7'd0;
    o_sof      = o_valid && (head.x == 7'd0) && (head.y == 7'd0);
    o_eol      = o_valid && (head.x == X_LAST);
  end

  // FIFO pointers, occupancy and in-flight tracking. Stop flushes everything.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    if (i_rst || i_stop) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      inflight <= 1'b0;
      fl_x     <= 7'd0;
      fl_y     <= 7'd0;
    end else begin
      inflight <= issue;
      fl_x     <= rd_x;
      fl_y     <= rd_y;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // FIFO storage: returned RAM data is captured along with its coordinates.
  always_ff @(posedge i_clk) begin
    // NOTE: the storage array is not reset; the occupancy count decides what is valid, and the outputs are gated while empty.
    if (push) fifo_mem[wr_ptr] <= '{pixel: i_ram_q, x: fl_x, y: fl_y};
  end

  // Frame FSM: read address and coordinate counters, and the frame-done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      addr   <= 14'd0;
      rd_x   <= 7'd0;
      rd_y   <= 7'd0;
      o_done <= 1'b0;
    end else begin
      o_done <= pop && head_last && !i_stop;
      if (i_stop) begin
        state <= S_IDLE;
        addr  <= 14'd0;
        rd_x  <= 7'd0;
        rd_y  <= 7'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              state <= S_RUN;
              addr  <= 14'd0;
              rd_x  <= 7'd0;
              rd_y  <= 7'd0;
            end
          end
          S_RUN: begin
            if (issue) begin
              if (addr == LAST_ADDR) begin
                addr <= 14'd0;
                rd_x <= 7'd0;
                rd_y <= 7'd0;
                if (!i_loop) state <= S_DRAIN;
              end else begin
                addr <= addr + 14'd1;
                if (rd_x == X_LAST) begin
                  rd_x <= 7'd0;
                  rd_y <= (rd_y == Y_LAST) ? 7'd0 : rd_y + 7'd1;
                end else begin
                  rd_x <= rd_x + 7'd1;
                end
              end
            end
          end
          S_DRAIN: begin
            if (pop && head_last) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_reader.sv
// Self-checking bench for image_reader. It models the RAM and keeps a
// scoreboard of the expected read addresses and pixel stream, built from
// frame-position arithmetic. Directed phases cover the following:
// latency and full-frame throughput, a random stall pattern, stop with a
// full FIFO, two looped frames, and reset in the middle of a frame.
module tb_image_reader;
  localparam int W = 128;
  localparam int H = 128;
  localparam int N = W * H;

  logic        clk, rst, start, loop_en, stop, ready;
  logic [13:0] ram_addr;
  logic        ram_rd;
  logic [23:0] ram_q;
  logic [23:0] pixel;
  logic        valid;
  logic [6:0]  px, py;
  logic        sof, eol, busy, done;

  image_reader #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_loop(loop_en), .i_stop(stop),
    .o_ram_addr(ram_addr), .o_ram_rd(ram_rd), .i_ram_q(ram_q),
    .o_pixel(pixel), .o_valid(valid), .i_ready(ready),
    .o_x(px), .o_y(py), .o_sof(sof), .o_eol(eol),
    .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM model: data is a per-test salt above the address, valid one cycle after the read.
  logic [9:0] salt;
  always @(posedge clk) ram_q <= ram_rd ? {salt, ram_addr} : 24'($urandom);

  // Scoreboard, which samples on the falling edge.
  int          pix;       // frame position of the next expected pixel
  int          issued;    // reads issued since the last reset/stop
  int          xfer;      // pixels transferred since the last reset/stop
  logic [13:0] exp_addr;
  logic        done_exp;
  logic        prev_stall;
  logic [39:0] prev_out;

  always @(negedge clk) begin
    if (rst) begin
      pix = 0; issued = 0; xfer = 0; exp_addr = 14'd0;
      done_exp = 1'b0; prev_stall = 1'b0;
    end else begin
      logic pop;
      int   p;
      check_eq("done_pulse", 64'(done), 64'(done_exp));
      if (prev_stall) begin
        check_eq("stall_valid", 64'(valid), 64'd1);
        check_eq("stall_hold", 64'({pixel, px, py, sof, eol}), 64'(prev_out));
      end
      pop = valid && ready;
      if (ram_rd) begin
        check_eq("rd_addr", 64'(ram_addr), 64'(exp_addr));
        check_eq("rd_room", 64'((issued - xfer - int'(pop)) < 2), 64'd1);
        issued++;
        exp_addr = (int'(exp_addr) == N - 1) ? 14'd0 : exp_addr + 14'd1;
      end
      done_exp = 1'b0;
      if (pop) begin
        p = pix;
        check_eq("pixel", 64'(pixel), 64'({salt, 14'(p)}));
        check_eq("xy_flags", 64'({px, py, sof, eol}),
                 64'({7'(p % W), 7'(p / W), (p == 0), (p % W == W - 1)}));
        xfer++;
        done_exp = (p == N - 1) && !stop;
        pix = (p + 1) % N;
      end
      prev_stall = valid && !ready && !stop;
      prev_out   = {pixel, px, py, sof, eol};
      if (stop) begin
        pix = 0; issued = 0; xfer = 0; exp_addr = 14'd0; done_exp = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts the cycles from the current one until o_done, stopping after a fixed number of cycles.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step();
      n++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k;
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; stop = 1'b0; ready = 1'b0; salt = 10'd0;
    repeat (3) step();
    @(negedge clk);
    check_eq("reset_outputs", 64'({valid, ram_rd, busy, done, px, py, sof, eol}), 64'd0);
    step();
    rst = 1'b0;

    // Full frame with RAM[a]=a and ready held high: latency and throughput.
    ready = 1'b1;
    step();
    start = 1'b1;                      // cycle T
    @(negedge clk);
    check_eq("lat_T_rd", 64'(ram_rd), 64'd0);
    step(); start = 1'b0;              // T+1
    @(negedge clk);
    check_eq("lat_T1_rd", 64'(ram_rd), 64'd1);
    check_eq("lat_T1_valid", 64'(valid), 64'd0);
    check_eq("lat_T1_busy", 64'(busy), 64'd1);
    step();                            // T+2
    @(negedge clk);
    check_eq("lat_T2_valid", 64'(valid), 64'd0);
    step();                            // T+3
    @(negedge clk);
    check_eq("lat_T3_valid", 64'(valid), 64'd1);
    wait_done(N + 20, n);
    check_eq("frame_cycles", 64'(n), 64'(N));
    step();
    @(negedge clk);
    check_eq("idle_after_frame", 64'(busy), 64'd0);

    // Random stalls at 30% ready, with a stray i_start while busy; then stop.
    salt = 10'($urandom);
    step();
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 9) < 3);
      start = (i == 1000);
      step();
    end
    start = 1'b0; ready = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check_eq("stop_flush_valid", 64'(valid), 64'd0);
    check_eq("stop_idle", 64'(busy), 64'd0);

    // Stop at pixel 500 with the FIFO full, then restart from address 0.
    salt = 10'($urandom);
    step();
    ready = 1'b1;
    pulse_start();
    k = 0;
    while (pix < 500 && k < 1000) begin
      step();
      k++;
    end
    check_eq("reach_500", 64'(pix), 64'd500);
    ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_eq("full_valid", 64'(valid), 64'd1);
    check_eq("full_no_rd", 64'(ram_rd), 64'd0);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check_eq("stop500_valid", 64'(valid), 64'd0);
    check_eq("stop500_idle", 64'(busy), 64'd0);
    repeat (3) step();

    // Two looped frames: no bubble at the wrap, and one o_done per frame.
    salt = 10'($urandom);
    loop_en = 1'b1;
    ready = 1'b1;
    pulse_start();
    wait_done(N + 20, n);
    check_eq("loop_done1", 64'(done), 64'd1);
    step();
    loop_en = 1'b0;
    @(negedge clk);
    wait_done(N + 20, n);
    check_eq("loop_gap", 64'(n + 1), 64'(N));
    step();
    @(negedge clk);
    check_eq("loop_idle", 64'(busy), 64'd0);

    // Reset in the middle of a frame.
    salt = 10'($urandom);
    step();
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      ready = ($urandom_range(0, 1) == 1);
      step();
    end
    ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_outputs", 64'({valid, ram_rd, busy, done, px, py, sof, eol}), 64'd0);
    repeat (5) step();
    @(negedge clk);
    check_eq("rst_no_xfer", 64'(valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_reader.md
IMAGE_READER -- requirements
Module: image_reader

Interface
REQ-001 Parameter IMG_W, default 128, pixels per line.
REQ-002 Parameter IMG_H, default 128, lines per frame; IMG_W*IMG_H SHALL be <= 16384.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  single-cycle pulse, begins a frame readout.
REQ-006 i_loop  input  1  1 = restart at pixel 0 after the last pixel; sampled at each frame end.
REQ-007 i_stop  input  1  abort request.
REQ-008 o_ram_addr  output  14  read address to the 24-bit image RAM.
REQ-009 o_ram_rd  output  1  read issued this cycle.
REQ-010 i_ram_q  input  24  RAM read data, valid exactly 1 cycle after the issuing cycle.
REQ-011 o_pixel  output  24  pixel to downstream.
REQ-012 o_valid / i_ready  output / input  1 / 1  handshake; transfer when both high.
REQ-013 o_x, o_y  output  7, 7  coordinates of o_pixel.
REQ-014 o_sof, o_eol  output  1, 1  o_pixel is pixel (0,0) / last pixel of its line.
REQ-015 o_busy, o_done  output  1, 1  FSM not IDLE / one-cycle pulse at frame completion.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on i_start; RUN->DRAIN after the read of address IMG_W*IMG_H-1 issues and i_loop=0; DRAIN->IDLE when the last pixel transfers.
REQ-017 With i_loop=1 at the last read, the address SHALL wrap to 0 and RUN SHALL continue, with no bubble.
REQ-018 Read address counter SHALL start at 0, increment by 1 per issued read, and never exceed IMG_W*IMG_H-1.
REQ-019 Return data SHALL enter a 2-entry output FIFO; o_valid = FIFO non-empty; o_pixel = FIFO head.
REQ-020 A read SHALL issue in RUN only when (FIFO count + in-flight read - pop this cycle) < 2; the FIFO SHALL never overflow.
REQ-021 With i_ready held high, throughput SHALL be one pixel per cycle after the first.
REQ-022 Latency: i_start in cycle T -> first o_ram_rd in T+1 -> first o_valid in T+3.
REQ-023 o_pixel, o_x, o_y, o_sof, o_eol SHALL stay stable while o_valid=1 and i_ready=0.
REQ-024 o_x/o_y SHALL travel with each FIFO entry; o_x wraps IMG_W-1->0 with o_y+1; o_y wraps IMG_H-1->0.
REQ-025 o_done SHALL pulse for the one cycle after the last pixel of a frame transfers, in both loop and non-loop modes.
REQ-026 i_start SHALL be ignored when not in IDLE.
REQ-027 i_stop in any state SHALL flush the FIFO, discard the in-flight read, and go to IDLE the next cycle; o_done is not pulsed; i_stop overrides a simultaneous i_start.

Reset
REQ-028 On i_rst: state IDLE, address 0, FIFO empty, in-flight cleared, o_valid=0, o_ram_rd=0, o_busy=0, o_done=0, o_x=o_y=0, o_sof=o_eol=0.
REQ-029 i_rst asserted mid-frame SHALL take effect at the next edge with no further pixel transfers.

Verification
REQ-030 Reset, i_start at T, i_ready=1, RAM[a]=a -> o_ram_rd at T+1, o_valid at T+3, 16384 pixels 0..16383 on consecutive cycles, o_done one cycle after pixel 16383.
REQ-031 Random i_ready at 30% duty -> every pixel in order, none lost or duplicated, outputs stable while stalled, o_ram_rd never issued with 2 entries committed.
REQ-032 i_loop=1 for 2 frames -> pixel 16383 followed immediately by pixel 0 with o_sof=1, two o_done pulses.
REQ-033 o_eol on o_x=127; o_sof only on (0,0); o_y increments after each o_eol.
REQ-034 i_stop at pixel 500 with FIFO full -> o_valid=0 next cycle, IDLE, no o_done; fresh i_start restarts at address 0.
REQ-035 i_start while busy -> ignored, address sequence unaffected.
